// File: rtl/rx_demux_decoder.sv
// Receive-side 2-bit symbol demux: routes symbols by {sB,sA} to two word assemblers, flags 10/11 selects.
// Optional saturating drop counter on port err_count when RX_DEMUX_ERRCNT_EN is defined.

module rx_demux_lane #(
  parameter int SPW = 4,
  parameter int W   = 2*SPW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit,
  input  logic         flush,
  input  logic [1:0]   sym,
  output logic [W-1:0] data,
  output logic         valid
);
  localparam int CW = (SPW > 1) ? $clog2(SPW) : 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  asm_q, asm_nxt;
  logic          last;

  // Assembler above the current slot is always zero, so the final word is asm_nxt as-is.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{cnt, 1'b0} +: 2] = sym;
  end

  assign last = (cnt == CW'(SPW-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      asm_q <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        cnt   <= '0;
        asm_q <= '0;
      end else if (hit) begin
        if (last) begin
          data  <= asm_nxt;
          valid <= 1'b1;
          cnt   <= '0;
          asm_q <= '0;
        end else begin
          cnt   <= cnt + CW'(1);
          asm_q <= asm_nxt;
        end
      end
    end
  end
endmodule

module rx_demux_decoder #(
  parameter  int SYMS_PER_WORD = 4,
  localparam int W             = 2*SYMS_PER_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sB,
  input  logic         sA,
  input  logic [1:0]   sym_in,
  input  logic         sym_valid,
  input  logic         flush,
  output logic [W-1:0] ch0_data,
  output logic         ch0_valid,
  output logic [W-1:0] ch1_data,
  output logic         ch1_valid,
  output logic         err_sel
`ifdef RX_DEMUX_ERRCNT_EN
  , output logic [7:0] err_count
`endif
);
  logic [1:0][W-1:0] data;
  logic [1:0]        valid;
  logic              accept;

  assign accept = sym_valid & ~flush;

  for (genvar c = 0; c < 2; c++) begin : g_lane
    rx_demux_lane #(.SPW(SYMS_PER_WORD), .W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (accept && ({sB, sA} == 2'(c))),
      .flush (flush),
      .sym   (sym_in),
      .data  (data[c]),
      .valid (valid[c])
    );
  end

  assign ch0_data  = data[0];
  assign ch0_valid = valid[0];
  assign ch1_data  = data[1];
  assign ch1_valid = valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sel <= 1'b0;
    else        err_sel <= accept & sB;
  end

`ifdef RX_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_count <= 8'h00;
    else if (flush)                            err_count <= 8'h00;
    else if (accept && sB && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end
`endif
endmodule

// File: tb/tb_rx_demux_decoder.sv
// Randomized bench for rx_demux_decoder: queue-based channel model checked every cycle plus directed literals.
module tb_rx_demux_decoder;
  localparam int SPW = 4;
  localparam int W   = 2*SPW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sB = 1'b0, sA = 1'b0;
  logic [1:0]   sym_in = 2'b00;
  logic         sym_valid = 1'b0, flush = 1'b0;
  logic [W-1:0] ch0_data, ch1_data;
  logic         ch0_valid, ch1_valid, err_sel;
`ifdef RX_DEMUX_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  rx_demux_decoder #(.SYMS_PER_WORD(SPW)) dut (
    .clk(clk), .rst_n(rst_n), .sB(sB), .sA(sA), .sym_in(sym_in),
    .sym_valid(sym_valid), .flush(flush),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid),
    .err_sel(err_sel)
`ifdef RX_DEMUX_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue of received symbols; a word is emitted when the queue holds SPW.
  logic [1:0]   q0[$], q1[$];
  logic [W-1:0] e_d0, e_d1;
  logic         e_v0, e_v1, e_err;
  int           e_cnt;

  function automatic logic [W-1:0] pack(input logic [1:0] q[$]);
    logic [W-1:0] w = '0;
    for (int k = 0; k < q.size(); k++) w = w | (W'(q[k]) << (2*k));
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0; e_err = 0; e_cnt = 0;
    end else begin
      e_v0 = 0; e_v1 = 0; e_err = 0;
      if (flush) begin
        q0.delete(); q1.delete(); e_cnt = 0;
      end else if (sym_valid) begin
        case ({sB, sA})
          2'b00: begin
            q0.push_back(sym_in);
            if (q0.size() == SPW) begin e_d0 = pack(q0); e_v0 = 1; q0.delete(); end
          end
          2'b01: begin
            q1.push_back(sym_in);
            if (q1.size() == SPW) begin e_d1 = pack(q1); e_v1 = 1; q1.delete(); end
          end
          default: begin
            e_err = 1;
            if (e_cnt < 255) e_cnt++;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("ch0_data", 32'(ch0_data), 32'(e_d0));
    chk("ch0_valid", 32'(ch0_valid), 32'(e_v0));
    chk("ch1_data", 32'(ch1_data), 32'(e_d1));
    chk("ch1_valid", 32'(ch1_valid), 32'(e_v1));
    chk("err_sel", 32'(err_sel), 32'(e_err));
`ifdef RX_DEMUX_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(e_cnt));
`endif
  end

  task automatic send(input logic [1:0] sel, input logic [1:0] s, input logic v, input logic f);
    {sB, sA} = sel; sym_in = s; sym_valid = v; flush = f;
    @(posedge clk); #1;
    sym_valid = 0; flush = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset ch0_data", 32'(ch0_data), 32'h0);
    chk("reset pulses", 32'({ch0_valid, ch1_valid, err_sel}), 32'h0);
    rst_n = 1;

    // consecutive ch0 symbols, word 8'h39
    send(2'b00, 2'b01, 1, 0); send(2'b00, 2'b10, 1, 0); send(2'b00, 2'b11, 1, 0);
    chk("t1 no early valid", 32'(ch0_valid), 32'h0);
    send(2'b00, 2'b00, 1, 0);
    chk("t1 ch0_data", 32'(ch0_data), 32'h39);
    chk("t1 ch0_valid", 32'(ch0_valid), 32'h1);

    // interleaved channels keep partial words
    send(2'b00, 2'b11, 1, 0); send(2'b00, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) send(2'b01, 2'b11, 1, 0);
    chk("t2 ch1_data", 32'(ch1_data), 32'hFF);
    chk("t2 ch1_valid", 32'(ch1_valid), 32'h1);
    send(2'b00, 2'b00, 1, 0); send(2'b00, 2'b10, 1, 0);
    chk("t2 ch0_data", 32'(ch0_data), 32'h87);

    // select 10 drops the symbol
    send(2'b10, 2'b11, 1, 0);
    chk("t3 err_sel", 32'(err_sel), 32'h1);
`ifdef RX_DEMUX_ERRCNT_EN
    chk("t3 err_count", 32'(err_count), 32'h1);
`endif
    for (int i = 0; i < 4; i++) send(2'b00, 2'b00, 1, 0);
    chk("t3 ch0_data", 32'(ch0_data), 32'h00);
    chk("t3 ch0_valid", 32'(ch0_valid), 32'h1);
`ifdef RX_DEMUX_ERRCNT_EN
    for (int i = 0; i < 300; i++) send(2'b11, 2'(i), 1, 0);
    chk("t3 err_count sat", 32'(err_count), 32'hFF);
`endif

    // async reset mid-word
    send(2'b01, 2'b10, 1, 0); send(2'b01, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) send(2'b01, 2'b01, 1, 0);
    send(2'b00, 2'b01, 1, 0); send(2'b00, 2'b01, 1, 0);
    #3 rst_n = 0;
    #1;
    chk("t4 async ch1_data", 32'(ch1_data), 32'h0);
    chk("t4 async pulses", 32'({ch0_valid, ch1_valid, err_sel}), 32'h0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(2'b00, 2'b10, 1, 0);
    chk("t4 ch0_data", 32'(ch0_data), 32'hAA);

    // flush discards partial ch1 word
    send(2'b01, 2'b11, 1, 0); send(2'b01, 2'b11, 1, 0);
    send(2'b01, 2'b00, 1, 1);
    chk("t5 flush no pulse", 32'({ch0_valid, ch1_valid, err_sel}), 32'h0);
    for (int i = 0; i < 4; i++) send(2'b01, 2'b01, 1, 0);
    chk("t5 ch1_data", 32'(ch1_data), 32'h55);
    chk("t5 ch0 held", 32'(ch0_data), 32'hAA);

    // gaps between symbols
    send(2'b00, 2'b10, 1, 0); repeat (3) send(2'b00, 2'b11, 0, 0);
    send(2'b00, 2'b01, 1, 0); repeat (3) send(2'b00, 2'b11, 0, 0);
    send(2'b00, 2'b11, 1, 0); repeat (3) send(2'b00, 2'b11, 0, 0);
    send(2'b00, 2'b00, 1, 0);
    chk("t6 ch0_data", 32'(ch0_data), 32'h36);
    chk("t6 ch0_valid", 32'(ch0_valid), 32'h1);

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] sel = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
      end
      send(sel, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
